// File: rtl/ram_dma_copy.sv
// Block copy / constant fill engine for a shared-bus asynchronous single-port RAM.
// Latency: copy takes 2 cycles per word (RD then WR), fill 1 cycle per word, done pulses one cycle after the last write.
// Backpressure: none; start is honoured only in IDLE, abort ends the active operation at the next edge.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, mode, abort  request (mode 0 = copy, 1 = fill), early termination
//   src, dst, len       source/destination base addresses, word count 0..2^A
//   fill_val            fill constant
//   busy, done          operation active, one-cycle completion pulse
//   ram_addr, ram_we    RAM address and write enable
//   ram_data            shared RAM data bus; driven by this block only while ram_we=1
module ram_dma_copy #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         mode,
    input  logic         abort,
    input  logic [A-1:0] src,
    input  logic [A-1:0] dst,
    input  logic [A:0]   len,
    input  logic [D-1:0] fill_val,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] ram_addr,
    output logic         ram_we,
    inout  wire  [D-1:0] ram_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A:0]   len_q, len_d;
    logic         mode_q, mode_d;
    logic [D-1:0] fill_q, fill_d;
    logic [D-1:0] data_q, data_d;
    logic [A:0]   idx_q, idx_d;
    logic [A-1:0] addr_q, addr_d;

    logic [A:0]   idx_inc;
    logic [D-1:0] wr_dat;

    assign idx_inc = idx_q + (A+1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    // The address register is loaded with the address of the state being
    // entered, so ram_addr is a clean register output and simply holds its
    // last value across FIN, IDLE and abort.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        data_d  = data_q;
        idx_d   = idx_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                // abort is meaningless here, so a simultaneous start wins.
                if (start) begin
                    src_d  = src;
                    dst_d  = dst;
                    len_d  = len;
                    mode_d = mode;
                    fill_d = fill_val;
                    idx_d  = '0;
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else if (mode) begin
                        state_d = S_WR;
                        addr_d  = dst;
                    end else begin
                        state_d = S_RD;
                        addr_d  = src;
                    end
                end
            end

            S_RD: begin
                data_d = ram_data;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR;
                    addr_d  = dst_q + idx_q[A-1:0];
                end
            end

            S_WR: begin
                // The write itself happens at this edge regardless of abort,
                // because the RAM samples ram_we on the same edge.
                idx_d = idx_inc;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_inc == len_q) begin
                    state_d = S_FIN;
                end else if (mode_q) begin
                    state_d = S_WR;
                    addr_d  = dst_q + idx_inc[A-1:0];
                end else begin
                    state_d = S_RD;
                    addr_d  = src_q + idx_inc[A-1:0];
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only.
    assign ram_addr = addr_q;
    assign ram_we   = (state_q == S_WR);
    assign done     = (state_q == S_FIN);
    // A zero-length request consists only of its FIN cycle; busy covers that
    // cycle so the request is visible. Normal operations drop busy in FIN.
    assign busy     = (state_q == S_RD) || (state_q == S_WR) ||
                      ((state_q == S_FIN) && (len_q == '0));

    assign wr_dat   = mode_q ? fill_q : data_q;
    // Drive enable is exactly ram_we, so the block never fights the RAM.
    assign ram_data = ram_we ? wr_dat : {D{1'bz}};

endmodule

// File: tb/tb_ram_dma_copy.sv
module tb_ram_dma_copy;

    localparam int A = 10;
    localparam int D = 8;
    localparam int N = 1024;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         mode;
    logic         abort;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A:0]   len;
    logic [D-1:0] fill_val;
    logic         busy;
    logic         done;
    logic [A-1:0] ram_addr;
    logic         ram_we;
    wire  [D-1:0] ram_data;

    int checks   = 0;
    int failures = 0;
    int bus_bad  = 0;

    // RAM model: combinational read onto the bus when ram_we=0, write on the
    // rising edge when ram_we=1. Bench-side init/preload share the write port.
    logic [D-1:0] mem [N];
    logic [D-1:0] ref_mem [N];
    logic         init_en;
    logic         pl_en;
    logic [A-1:0] pl_addr;
    logic [D-1:0] pl_dat;

    assign ram_data = (!ram_we) ? mem[ram_addr] : {D{1'bz}};

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_dat;
        end
    end

    // Whenever the DUT is not writing, the bus must carry the RAM's word.
    always @(negedge clk) begin
        if (!ram_we && (ram_data !== mem[ram_addr])) bus_bad++;
    end

    ram_dma_copy #(.A(A), .D(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_data (ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Reference model: words written in ascending order, each copy word read
    // after all earlier writes, so overlapping copies propagate naturally.
    task automatic ref_apply(input bit m, input int s, input int d, input int nw, input int f);
        for (int k = 0; k < nw; k++) begin
            if (m) ref_mem[(d + k) % N] = 8'(f);
            else   ref_mem[(d + k) % N] = ref_mem[(s + k) % N];
        end
    endtask

    task automatic poke(input int a, input int v);
        pl_addr = 10'(a);
        pl_dat  = 8'(v);
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
        ref_mem[a % N] = 8'(v);
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge.
    task automatic run_op(input string tag, input bit m, input int s, input int d,
                          input int l, input int f, input int abort_at,
                          input bit inj_start, input bit fin_start);
        int busy_cnt = 0, we_cnt = 0, done_cnt = 0, done_idx = -1, seq_err = 0;
        int c = 0, bb0, nw, exp_busy;
        bit exp_we, idle_seen = 0;
        bb0      = bus_bad;
        src      = 10'(s);
        dst      = 10'(d);
        len      = 11'(l);
        mode     = m;
        fill_val = 8'(f);
        start    = 1'b1;
        abort    = 1'b1;   // start must win over abort in IDLE
        @(negedge clk);
        while (c < 3000) begin
            start = 1'b0;
            abort = 1'b0;
            if (!busy && !done) begin
                idle_seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_idx = c;
            end
            exp_we = (busy && !done) ? (m ? 1'b1 : c[0]) : 1'b0;
            if (ram_we !== exp_we) seq_err++;
            if (ram_we) begin
                if (ram_addr !== 10'((d + we_cnt) % N)) seq_err++;
                if (m && (ram_data !== 8'(f))) seq_err++;
                we_cnt++;
                if (abort_at > 0 && we_cnt == abort_at) abort = 1'b1;
            end
            if (inj_start && c == 1) begin
                start = 1'b1;
                src   = ~10'(s);
                dst   = ~10'(d);
                len   = 11'd5;
            end
            if (fin_start && done) begin
                start = 1'b1;
                mode  = 1'b1;
                dst   = 10'h300;
                len   = 11'd5;
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_timeout"}, 32'(idle_seen), 32'd1);
        nw       = (abort_at > 0) ? abort_at : l;
        exp_busy = (l == 0) ? 1 : (m ? nw : 2 * nw);
        ref_apply(m, s, d, nw, f);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk({tag, "_done_count"}, 32'(done_cnt), (abort_at > 0) ? 32'd0 : 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_idx),
            (abort_at > 0) ? 32'hFFFF_FFFF : ((l == 0) ? 32'd0 : 32'(exp_busy)));
        chk({tag, "_writes"}, 32'(we_cnt), 32'(nw));
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_bus"}, 32'(bus_bad - bb0), 32'd0);
        chk({tag, "_mem"}, 32'(mem_diffs()), 32'd0);
    endtask

    initial begin
        int m, s, d, l, f, ab;
        reset_n  = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        src      = '0;
        dst      = '0;
        len      = '0;
        fill_val = '0;
        init_en  = 1'b0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_dat   = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        reset_n = 1'b1;
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = 8'(i * 37 + 11);

        // Fill 4 words at 0x100.
        run_op("fill", 1, 0, 'h100, 4, 'hA5, 0, 0, 0);
        for (int i = 0; i < 4; i++) chk("fill_word", 32'(mem['h100 + i]), 32'hA5);

        // Copy 3 words, with a second start injected mid-operation.
        poke('h010, 'h11);
        poke('h011, 'h22);
        poke('h012, 'h33);
        run_op("copy", 0, 'h010, 'h200, 3, 0, 0, 1, 0);
        chk("copy_w0", 32'(mem['h200]), 32'h11);
        chk("copy_w2", 32'(mem['h202]), 32'h33);

        // Wrapping, overlapping copy propagates the first word.
        poke('h3FE, 'h01);
        run_op("wrap", 0, 'h3FE, 'h3FF, 3, 0, 0, 0, 0);
        chk("wrap_3ff", 32'(mem['h3FF]), 32'h01);
        chk("wrap_000", 32'(mem['h000]), 32'h01);
        chk("wrap_001", 32'(mem['h001]), 32'h01);

        // Zero length, with a start presented during FIN.
        run_op("len0", 0, 'h050, 'h060, 0, 0, 0, 0, 1);

        // Abort on the third fill write, then an immediate new start.
        run_op("abort", 1, 0, 'h040, 8, 'h5C, 3, 0, 0);
        run_op("post_abort", 1, 0, 'h048, 2, 'h77, 0, 0, 0);

        // Asynchronous reset while in RD.
        src   = 10'h123;
        dst   = 10'h321;
        len   = 11'd4;
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rd_addr", 32'(ram_addr), 32'h123);
        chk("rd_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("arst_mem", 32'(mem_diffs()), 32'd0);

        // Randomised operations against the reference model.
        for (int it = 0; it < 10; it++) begin
            m  = int'($urandom_range(0, 1));
            s  = int'($urandom_range(0, N - 1));
            d  = int'($urandom_range(0, N - 1));
            l  = int'($urandom_range(0, 24));
            f  = int'($urandom_range(0, 255));
            ab = (l > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, l - 1)) : 0;
            run_op("rand", m[0], s, d, l, f, ab, 0, 0);
        end

        // Whole-RAM overlapping copy.
        run_op("full", 0, 'h155, 'h15A, N, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
